alarm_scanner: RTL and testbench
================================

# alarm_scanner

Read-side companion of the seven-entry alarm register file: on every minute boundary it walks the registers one per cycle through a read select, compares each armed 13-bit alarm word against the current time and raises the ring output on a match. It also handles stop, snooze and ring timeout. It sits between the register file outputs (via a 7:1 read mux) and the buzzer/display logic of the alarm clock.

## Interface
- NUM_REGS, 7, number of alarm registers scanned (indices 0..NUM_REGS-1)
- SNOOZE_MIN, 9, minute ticks spent in snooze before re-ringing
- RING_TIMEOUT_MIN, 5, minute ticks of unattended ringing before auto-stop
- Clock  in  1  single system clock, all state on rising edge
- Clear  in  1  asynchronous active-low reset
- min_tick  in  1  one-cycle pulse at each minute boundary
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- rd_data  in  13  register file word selected by RSEL, valid combinationally in the same cycle
- Stop  in  1  one-cycle pulse, silence and cancel alarm
- Snooze  in  1  one-cycle pulse, silence and re-ring later
- RSEL  out  3  read select into register file
- Alarm  out  1  ring request
- Alarm_idx  out  3  index of the register that caused the ring
- Snoozing  out  1  high while in SNOOZE
- Busy  out  1  high while in SCAN

## Operation
- Alarm word: bit 12 armed, bit 11 ignored, bits 10:6 hour, bits 5:0 minute. Match = armed & hour==cur_hour & minute==cur_min. A word with hour>23 or minute>59 never matches.
- States: IDLE, SCAN, RING, SNOOZE. Reset enters IDLE.
- IDLE: RSEL=0. On min_tick, go to SCAN and clear the match flag.
- SCAN: each cycle compare rd_data, then increment RSEL. The first (lowest-index) match sets the match flag and latches RSEL into Alarm_idx; later matches do not overwrite it. After the compare at RSEL=NUM_REGS-1: go to RING if matched, else IDLE. In both cases RSEL returns to 0. RSEL never reaches 7.
- RING: Alarm=1, ring-minute counter cleared on entry.
  - Each min_tick increments the counter. When the counter reaches RING_TIMEOUT_MIN, go to IDLE.
  - Stop: go to IDLE.
  - Snooze: go to SNOOZE, load the snooze counter with SNOOZE_MIN.
- SNOOZE: Alarm=0, Snoozing=1.
  - Each min_tick decrements the counter. At zero, go to RING with the same Alarm_idx.
  - Stop: go to IDLE.
  - Snooze: ignored.
- Simultaneous events:
  - Stop and Snooze in the same cycle: Stop wins.
  - Stop/Snooze coinciding with the terminal min_tick: Stop/Snooze wins.
- min_tick handling outside IDLE:
  - In SCAN it is ignored.
  - In RING and SNOOZE it does not start a scan; alarms due during that time are not reported.
- Stop/Snooze in IDLE or SCAN: ignored.
- Alarm_idx holds its last value in IDLE.

## Timing
- Reset values: RSEL=0, Alarm=0, Alarm_idx=0, Snoozing=0, Busy=0, counters=0.
- Clear is asynchronous and takes effect immediately. A reset mid-SCAN or mid-RING drops Alarm in the same instant; no ring resumes afterwards.
- Scan latency: min_tick sampled at edge t puts the block in SCAN after edge t. RSEL=0..6 is presented during cycles t+1..t+7, and Alarm rises after edge t+7. That is a 7-cycle latency from the min_tick edge to Alarm.
- Busy=1 exactly for the 7 SCAN cycles.
- Stop/Snooze sampled at edge e: Alarm falls after edge e.
- Snooze re-ring: Alarm rises after the edge sampling the SNOOZE_MIN-th min_tick.
- All outputs are registered except RSEL, which is state-register driven with no combinational path from inputs.

## Structure
- Shared package: alarm word field positions and widths (ARMED_BIT, HOUR_MSB/LSB, MIN_MSB/LSB), state encoding typedef, NUM_REGS default. The register-file side uses the same field definitions.
- Optional sub-module alarm_word_match: combinational armed/range/equality check of one word against the current time. It is reusable by the display logic.
- Counters are 4 bits wide. Parameters must be ≤15; elaboration check required.

## Test plan
- Reg 2 = 1_0_00111_011110 (armed 07:30), time 07:30, min_tick → RSEL steps 0..6, Busy high 7 cycles, Alarm=1 and Alarm_idx=2 after 7 cycles.
- Regs 1 and 4 both armed 07:30 → Alarm_idx=1. Same with reg 1 disarmed (bit 12=0) → Alarm_idx=4. With reg 1 set to hour 25 → no match from reg 1.
- Ringing, Snooze pulse → Alarm=0, Snoozing=1. After 9 min_ticks → Alarm=1, same idx. Stop and Snooze in the same cycle → IDLE, Alarm=0, Snoozing=0.
- Ringing with no user input → Alarm drops on the 5th min_tick; no rescan on that tick.
- Clear low mid-SCAN (at RSEL=3) and mid-RING → all outputs 0 immediately. After release, the next min_tick rescans from RSEL=0.

Source files
------------

// File: rtl/alarm_scanner_pkg.sv
// -----------------------------------------------------------------------------
// alarm_scanner_pkg
// Shared definitions for the alarm register file and its scanner. It holds the
// alarm word field layout, the scanner state encoding and the default number
// of registers. The register-file write side uses the same field positions,
// so both ends agree on where armed/hour/minute live.
// -----------------------------------------------------------------------------
package alarm_scanner_pkg;

  // Alarm word layout: [12] armed, [11] spare (ignored), [10:6] hour, [5:0] minute
  localparam int unsigned WORD_W    = 13;
  localparam int unsigned ARMED_BIT = 12;
  localparam int unsigned SPARE_BIT = 11;
  localparam int unsigned HOUR_MSB  = 10;
  localparam int unsigned HOUR_LSB  = 6;
  localparam int unsigned MIN_MSB   = 5;
  localparam int unsigned MIN_LSB   = 0;
  localparam int unsigned HOUR_W    = HOUR_MSB - HOUR_LSB + 1;
  localparam int unsigned MIN_W     = MIN_MSB - MIN_LSB + 1;

  // Largest legal time-of-day field values
  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // Register-file depth and counter width
  localparam int unsigned NUM_REGS_DEF = 7;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned CNT_MAX      = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } scan_state_t;

  // True when an armed, in-range alarm word equals the current time
  function automatic logic word_hit(
    input logic [WORD_W-1:0] word,
    input logic [HOUR_W-1:0] cur_hour,
    input logic [MIN_W-1:0]  cur_min
  );
    logic [HOUR_W-1:0] w_hour;
    logic [MIN_W-1:0]  w_min;
    logic              w_in_range;
    w_hour     = word[HOUR_MSB:HOUR_LSB];
    w_min      = word[MIN_MSB:MIN_LSB];
    w_in_range = (w_hour <= MAX_HOUR) && (w_min <= MAX_MIN);
    return word[ARMED_BIT] && w_in_range &&
           (w_hour == cur_hour) && (w_min == cur_min);
  endfunction

endpackage

// File: rtl/alarm_scanner_word_match.sv
// -----------------------------------------------------------------------------
// alarm_scanner_word_match
// Combinational check of one alarm word against the current time. Also usable
// by the display logic to highlight an alarm that is due right now.
// Ports:
//   i_word     [12:0] alarm word (armed / spare / hour / minute)
//   i_cur_hour [4:0]  current hour
//   i_cur_min  [5:0]  current minute
//   o_hit             armed, in range and equal to the current time
// -----------------------------------------------------------------------------
module alarm_scanner_word_match
  import alarm_scanner_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [HOUR_W-1:0] i_cur_hour,
  input  logic [MIN_W-1:0]  i_cur_min,
  output logic              o_hit
);

  // The spare bit carries no meaning for matching
  logic w_unused_spare;
  assign w_unused_spare = i_word[SPARE_BIT];

  assign o_hit = word_hit(i_word, i_cur_hour, i_cur_min);

endmodule

// File: rtl/alarm_scanner.sv
// -----------------------------------------------------------------------------
// alarm_scanner
// On each minute tick, walks the alarm registers one per cycle through the
// read select, finds the lowest-index armed word matching the current time and
// raises the ring request. Handles Stop, Snooze (re-ring after SNOOZE_MIN
// ticks) and auto-stop after RING_TIMEOUT_MIN unattended ticks.
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low clear
//   i_min_tick     one-cycle pulse per minute boundary
//   i_cur_hour     current hour (0..23)
//   i_cur_min      current minute (0..59)
//   i_rd_data      register word selected by o_rsel (same-cycle)
//   i_stop         one-cycle pulse: silence and cancel
//   i_snooze       one-cycle pulse: silence and re-ring later
//   o_rsel         read select into the register file
//   o_alarm        ring request
//   o_alarm_idx    register index that caused the ring
//   o_snoozing     high while snoozing
//   o_busy         high while scanning
// -----------------------------------------------------------------------------
module alarm_scanner
  import alarm_scanner_pkg::*;
#(
  parameter int unsigned NUM_REGS         = NUM_REGS_DEF,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_min_tick,
  input  logic [HOUR_W-1:0] i_cur_hour,
  input  logic [MIN_W-1:0]  i_cur_min,
  input  logic [WORD_W-1:0] i_rd_data,
  input  logic              i_stop,
  input  logic              i_snooze,
  output logic [2:0]        o_rsel,
  output logic              o_alarm,
  output logic [2:0]        o_alarm_idx,
  output logic              o_snoozing,
  output logic              o_busy
);

  // Elaboration-time parameter checks: counters are 4 bits, select is 3 bits
  generate
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > CNT_MAX) begin : g_bad_snooze
      $error("alarm_scanner: SNOOZE_MIN must be in 1..15");
    end
    if (RING_TIMEOUT_MIN < 1 || RING_TIMEOUT_MIN > CNT_MAX) begin : g_bad_timeout
      $error("alarm_scanner: RING_TIMEOUT_MIN must be in 1..15");
    end
    if (NUM_REGS < 1 || NUM_REGS > 7) begin : g_bad_regs
      $error("alarm_scanner: NUM_REGS must be in 1..7");
    end
  endgenerate

  localparam logic [2:0]       LAST_IDX   = 3'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LD  = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] RING_LIMIT = CNT_W'(RING_TIMEOUT_MIN);

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [2:0]       r_rsel;
  logic [2:0]       w_rsel_nxt;
  logic             r_matched;
  logic             w_matched_nxt;
  logic [2:0]       r_alarm_idx;
  logic [2:0]       w_alarm_idx_nxt;
  logic [CNT_W-1:0] r_ring_cnt;
  logic [CNT_W-1:0] w_ring_cnt_nxt;
  logic [CNT_W-1:0] w_ring_cnt_inc;
  logic [CNT_W-1:0] r_snz_cnt;
  logic [CNT_W-1:0] w_snz_cnt_nxt;
  logic             r_alarm;
  logic             r_snoozing;
  logic             r_busy;
  logic             w_hit;

  alarm_scanner_word_match u_match (
    .i_word     (i_rd_data),
    .i_cur_hour (i_cur_hour),
    .i_cur_min  (i_cur_min),
    .o_hit      (w_hit)
  );

  assign w_ring_cnt_inc = r_ring_cnt + 4'd1;

  // State register and all datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rsel      <= 3'd0;
      r_matched   <= 1'b0;
      r_alarm_idx <= 3'd0;
      r_ring_cnt  <= 4'd0;
      r_snz_cnt   <= 4'd0;
      r_alarm     <= 1'b0;
      r_snoozing  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsel      <= w_rsel_nxt;
      r_matched   <= w_matched_nxt;
      r_alarm_idx <= w_alarm_idx_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_snz_cnt   <= w_snz_cnt_nxt;
      // Outputs follow the next state so they change on the same edge
      r_alarm     <= (w_state_nxt == ST_RING);
      r_snoozing  <= (w_state_nxt == ST_SNOOZE);
      r_busy      <= (w_state_nxt == ST_SCAN);
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rsel_nxt      = r_rsel;
    w_matched_nxt   = r_matched;
    w_alarm_idx_nxt = r_alarm_idx;
    w_ring_cnt_nxt  = r_ring_cnt;
    w_snz_cnt_nxt   = r_snz_cnt;
    case (r_state)
      ST_IDLE: begin
        w_rsel_nxt = 3'd0;
        if (i_min_tick) begin
          w_state_nxt   = ST_SCAN;
          w_matched_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Only the first (lowest-index) hit is recorded
        if (w_hit && !r_matched) begin
          w_matched_nxt   = 1'b1;
          w_alarm_idx_nxt = r_rsel;
        end else begin
          w_matched_nxt = r_matched;
        end
        if (r_rsel == LAST_IDX) begin
          w_rsel_nxt = 3'd0;
          if (r_matched || w_hit) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_rsel_nxt = r_rsel + 3'd1;
        end
      end
      ST_RING: begin
        // User action outranks the timeout tick
        if (i_stop) begin
          w_state_nxt    = ST_IDLE;
          w_ring_cnt_nxt = 4'd0;
        end else if (i_snooze) begin
          w_state_nxt    = ST_SNOOZE;
          w_ring_cnt_nxt = 4'd0;
          w_snz_cnt_nxt  = SNOOZE_LD;
        end else if (i_min_tick) begin
          if (w_ring_cnt_inc == RING_LIMIT) begin
            w_state_nxt    = ST_IDLE;
            w_ring_cnt_nxt = 4'd0;
          end else begin
            w_ring_cnt_nxt = w_ring_cnt_inc;
          end
        end else begin
          w_state_nxt = ST_RING;
        end
      end
      ST_SNOOZE: begin
        // Snooze pulses are ignored here; ticks count down to the re-ring
        if (i_stop) begin
          w_state_nxt   = ST_IDLE;
          w_snz_cnt_nxt = 4'd0;
        end else if (i_min_tick) begin
          if (r_snz_cnt <= 4'd1) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = 4'd0;
            w_snz_cnt_nxt  = 4'd0;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 4'd1;
          end
        end else begin
          w_state_nxt = ST_SNOOZE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rsel_nxt  = 3'd0;
      end
    endcase
  end

  assign o_rsel      = r_rsel;
  assign o_alarm     = r_alarm;
  assign o_alarm_idx = r_alarm_idx;
  assign o_snoozing  = r_snoozing;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_alarm_scanner.sv
module tb_alarm_scanner;

  logic        clk;
  logic        rst_n;
  logic        min_tick;
  logic [4:0]  cur_hour;
  logic [5:0]  cur_min;
  logic [12:0] rd_data;
  logic        stop;
  logic        snooze;
  logic [2:0]  rsel;
  logic        alarm;
  logic [2:0]  alarm_idx;
  logic        snoozing;
  logic        busy;

  logic [12:0] regs [8];

  int checks;
  int failures;

  typedef struct {
    string            name;
    logic [6:0][12:0] words;
    logic [4:0]       hour;
    logic [5:0]       minute;
    logic             exp_alarm;
    logic [2:0]       exp_idx;
  } scan_vec_t;

  scan_vec_t vecs [9];

  alarm_scanner #(
    .NUM_REGS         (7),
    .SNOOZE_MIN       (9),
    .RING_TIMEOUT_MIN (5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_min_tick  (min_tick),
    .i_cur_hour  (cur_hour),
    .i_cur_min   (cur_min),
    .i_rd_data   (rd_data),
    .i_stop      (stop),
    .i_snooze    (snooze),
    .o_rsel      (rsel),
    .o_alarm     (alarm),
    .o_alarm_idx (alarm_idx),
    .o_snoozing  (snoozing),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file read mux model
  always_comb rd_data = regs[rsel];

  function automatic logic [12:0] aw(input logic armed, input logic [4:0] h, input logic [5:0] m);
    return {armed, 1'b0, h, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    min_tick = 1'b1;
    step();
    min_tick = 1'b0;
  endtask

  task automatic load_regs(input logic [6:0][12:0] w);
    for (int i = 0; i < 7; i++) regs[i] = w[i];
    regs[7] = 13'd0;
  endtask

  // Full scan: tick, 7 cycles of RSEL 0..6 with Busy, then result
  task automatic do_scan(input string name, input logic exp_alarm, input logic [2:0] exp_idx);
    pulse_tick();
    for (int k = 0; k < 7; k++) begin
      chk({name, "_rsel"}, 32'(rsel), 32'(k));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      chk({name, "_alarm_low"}, 32'(alarm), 32'd0);
      step();
    end
    chk({name, "_alarm"}, 32'(alarm), 32'(exp_alarm));
    chk({name, "_idx"}, 32'(alarm_idx), 32'(exp_idx));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_rsel_end"}, 32'(rsel), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rsel"}, 32'(rsel), 32'd0);
    chk({name, "_alarm"}, 32'(alarm), 32'd0);
    chk({name, "_idx"}, 32'(alarm_idx), 32'd0);
    chk({name, "_snoozing"}, 32'(snoozing), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic setup_0730_reg2();
    logic [6:0][12:0] w;
    w = '0;
    w[2] = aw(1'b1, 5'd7, 6'd30);
    load_regs(w);
    cur_hour = 5'd7;
    cur_min  = 6'd30;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    min_tick = 1'b0;
    stop     = 1'b0;
    snooze   = 1'b0;
    cur_hour = 5'd0;
    cur_min  = 6'd0;
    for (int i = 0; i < 8; i++) regs[i] = 13'd0;

    // Scan vectors: words, time, expected ring and index
    for (int i = 0; i < 9; i++) vecs[i].words = '0;
    vecs[0].name = "v0_reg2";      vecs[0].words[2] = aw(1'b1, 5'd7, 6'd30);
    vecs[0].hour = 5'd7;  vecs[0].minute = 6'd30; vecs[0].exp_alarm = 1'b1; vecs[0].exp_idx = 3'd2;
    vecs[1].name = "v1_first_wins"; vecs[1].words[1] = aw(1'b1, 5'd7, 6'd30); vecs[1].words[4] = aw(1'b1, 5'd7, 6'd30);
    vecs[1].hour = 5'd7;  vecs[1].minute = 6'd30; vecs[1].exp_alarm = 1'b1; vecs[1].exp_idx = 3'd1;
    vecs[2].name = "v2_disarmed";  vecs[2].words[1] = aw(1'b0, 5'd7, 6'd30); vecs[2].words[4] = aw(1'b1, 5'd7, 6'd30);
    vecs[2].hour = 5'd7;  vecs[2].minute = 6'd30; vecs[2].exp_alarm = 1'b1; vecs[2].exp_idx = 3'd4;
    vecs[3].name = "v3_hour25";    vecs[3].words[1] = aw(1'b1, 5'd25, 6'd30); vecs[3].words[4] = aw(1'b1, 5'd7, 6'd30);
    vecs[3].hour = 5'd7;  vecs[3].minute = 6'd30; vecs[3].exp_alarm = 1'b1; vecs[3].exp_idx = 3'd4;
    vecs[4].name = "v4_spare_bit"; vecs[4].words[6] = {1'b1, 1'b1, 5'd12, 6'd0};
    vecs[4].hour = 5'd12; vecs[4].minute = 6'd0;  vecs[4].exp_alarm = 1'b1; vecs[4].exp_idx = 3'd6;
    vecs[5].name = "v5_no_match";  vecs[5].words[0] = aw(1'b1, 5'd7, 6'd31);
    vecs[5].hour = 5'd7;  vecs[5].minute = 6'd30; vecs[5].exp_alarm = 1'b0; vecs[5].exp_idx = 3'd6;
    vecs[6].name = "v6_midnight";  vecs[6].words[0] = aw(1'b1, 5'd0, 6'd0);
    vecs[6].hour = 5'd0;  vecs[6].minute = 6'd0;  vecs[6].exp_alarm = 1'b1; vecs[6].exp_idx = 3'd0;
    vecs[7].name = "v7_hour_range"; vecs[7].words[3] = aw(1'b1, 5'd25, 6'd5);
    vecs[7].hour = 5'd25; vecs[7].minute = 6'd5;  vecs[7].exp_alarm = 1'b0; vecs[7].exp_idx = 3'd0;
    vecs[8].name = "v8_min_range"; vecs[8].words[5] = aw(1'b1, 5'd1, 6'd63);
    vecs[8].hour = 5'd1;  vecs[8].minute = 6'd63; vecs[8].exp_alarm = 1'b0; vecs[8].exp_idx = 3'd0;

    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // Stop/Snooze in IDLE are ignored
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    chk("idle_ignore_snoozing", 32'(snoozing), 32'd0);

    for (int v = 0; v < 9; v++) begin
      load_regs(vecs[v].words);
      cur_hour = vecs[v].hour;
      cur_min  = vecs[v].minute;
      do_scan(vecs[v].name, vecs[v].exp_alarm, vecs[v].exp_idx);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk({vecs[v].name, "_stopped"}, 32'(alarm), 32'd0);
      step();
    end

    // Snooze then re-ring after 9 ticks; Snooze inside SNOOZE is ignored
    setup_0730_reg2();
    do_scan("snz_scan", 1'b1, 3'd2);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snz_alarm_off", 32'(alarm), 32'd0);
    chk("snz_snoozing", 32'(snoozing), 32'd1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snz_reignore", 32'(snoozing), 32'd1);
    for (int t = 1; t <= 9; t++) begin
      pulse_tick();
      if (t < 9) begin
        chk("snz_wait_alarm", 32'(alarm), 32'd0);
        chk("snz_wait_busy", 32'(busy), 32'd0);
        chk("snz_wait_snoozing", 32'(snoozing), 32'd1);
      end else begin
        chk("snz_rering_alarm", 32'(alarm), 32'd1);
        chk("snz_rering_snoozing", 32'(snoozing), 32'd0);
        chk("snz_rering_idx", 32'(alarm_idx), 32'd2);
      end
      step();
    end
    // Stop and Snooze together: Stop wins
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    chk("both_alarm", 32'(alarm), 32'd0);
    chk("both_snoozing", 32'(snoozing), 32'd0);
    step();
    chk("both_stay_idle", 32'(snoozing), 32'd0);

    // Unattended ring times out on the 5th tick, with no rescan
    do_scan("to_scan", 1'b1, 3'd2);
    for (int t = 1; t <= 5; t++) begin
      pulse_tick();
      chk((t < 5) ? "to_ringing" : "to_dropped", 32'(alarm), (t < 5) ? 32'd1 : 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
    end
    step();
    chk("to_no_rescan", 32'(busy), 32'd0);
    chk("to_rsel", 32'(rsel), 32'd0);

    // Snooze coinciding with the terminal tick: Snooze wins
    do_scan("term_scan", 1'b1, 3'd2);
    for (int t = 1; t <= 4; t++) pulse_tick();
    min_tick = 1'b1; snooze = 1'b1;
    step();
    min_tick = 1'b0; snooze = 1'b0;
    chk("term_snoozing", 32'(snoozing), 32'd1);
    chk("term_alarm", 32'(alarm), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("term_stop_snoozing", 32'(snoozing), 32'd0);

    // Clear mid-SCAN at RSEL=3
    pulse_tick();
    for (int k = 0; k < 3; k++) step();
    chk("rst_scan_rsel3", 32'(rsel), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_scan");
    #2;
    rst_n = 1'b1;
    step();
    chk("rst_scan_after_busy", 32'(busy), 32'd0);
    do_scan("rst_rescan", 1'b1, 3'd2);

    // Clear mid-RING drops Alarm at once; no ring resumes
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_ring");
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("rst_ring_stays_off", 32'(alarm), 32'd0);
    do_scan("rst_ring_rescan", 1'b1, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
